// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared I2C command types and the command-arbiter FSM state encoding.
// Latency/backpressure: none (types and constants only).
package package_i2c;

  localparam int I2C_BURST_W = 8;
  // One extra bit so a full burst_num+1 byte count cannot wrap.
  localparam int I2C_BCNT_W  = I2C_BURST_W + 1;

  typedef struct packed {
    logic                   we;
    logic                   sccb_mode;
    logic [6:0]             addr_slave;
    logic [7:0]             addr_reg;
    logic [I2C_BURST_W-1:0] burst_num;
  } t_i2c_cmd;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_READ
  } t_i2c_arb_state;

endpackage

// File: rtl/i2c_rr_select.sv
// Round-robin requester select: captures a one-hot grant on load, advances past it on advance.
// Latency: grant registered one cycle after load; no backpressure.
module i2c_rr_select #(
  parameter int P_NUM_REQ = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [P_NUM_REQ-1:0]         i_req,
  input  logic                         i_load,
  input  logic                         i_advance,
  output logic [P_NUM_REQ-1:0]         o_grant,
  output logic [$clog2(P_NUM_REQ)-1:0] o_index
);

  localparam int IDX_W = $clog2(P_NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;

  // Scan from the furthest offset down so the nearest valid index at/after ptr wins.
  always_comb begin
    int j;
    j       = 0;
    cand    = '0;
    sel_idx = ptr;
    for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= P_NUM_REQ) j = j - P_NUM_REQ;
      cand = IDX_W'(j);
      if (i_req[cand]) sel_idx = cand;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr     <= '0;
      o_index <= '0;
      o_grant <= '0;
    end else begin
      if (i_load) begin
        o_index <= sel_idx;
        o_grant <= P_NUM_REQ'(1) << sel_idx;
      end
      if (i_advance)
        ptr <= (o_index == IDX_W'(P_NUM_REQ - 1)) ? '0 : o_index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C master among P_NUM_REQ requesters; o_cmd_valid 1 cycle after pick, grant held through read burst.
// Backpressure: valid/ready both sides; optional read-stall watchdog under I2C_CMD_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
  import package_i2c::*;
#(
  parameter int P_NUM_REQ        = 2,
  parameter int P_TIMEOUT_CYCLES = 65535
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic     [P_NUM_REQ-1:0]      i_req_valid,
  input  t_i2c_cmd [P_NUM_REQ-1:0]      i_req_cmd,
  input  logic     [P_NUM_REQ-1:0][7:0] i_req_wr_data,
  output logic     [P_NUM_REQ-1:0]      o_req_ready,
  output logic     [P_NUM_REQ-1:0]      o_req_rd_valid,
  output logic     [7:0]                o_req_rd_data,
  input  logic     [P_NUM_REQ-1:0]      i_req_rd_ready,
  output logic     [P_NUM_REQ-1:0]      o_grant,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic                          o_cmd_valid,
  output t_i2c_cmd                      o_cmd_data,
  output logic                          o_wr_valid,
  output logic     [7:0]                o_wr_data,
  input  logic                          i_cmd_ready,
  input  logic                          i_rd_valid,
  input  logic     [7:0]                i_rd_data,
  output logic                          o_rd_ready
);

  localparam int IDX_W = $clog2(P_NUM_REQ);

  t_i2c_arb_state          state, state_nxt;
  logic [IDX_W-1:0]        g_idx;
  logic [P_NUM_REQ-1:0]    grant_oh;
  logic                    rr_load, rr_adv, cnt_load, rd_hs;
  logic [I2C_BCNT_W-1:0]   byte_cnt;

  i2c_rr_select #(.P_NUM_REQ(P_NUM_REQ)) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_load    (rr_load),
    .i_advance (rr_adv),
    .o_grant   (grant_oh),
    .o_index   (g_idx)
  );

`ifdef I2C_CMD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(P_TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      wd_cnt <= '0;
    else if (state != S_READ || rd_hs) wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + WD_W'(1);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      byte_cnt <= '0;
    else if (cnt_load) byte_cnt <= {1'b0, i_req_cmd[g_idx].burst_num} + I2C_BCNT_W'(1);
    else if (rd_hs)    byte_cnt <= byte_cnt - I2C_BCNT_W'(1);
  end

  assign o_busy  = (state != S_IDLE);
  assign o_grant = o_busy ? grant_oh : '0;

  always_comb begin
    state_nxt      = state;
    rr_load        = 1'b0;
    rr_adv         = 1'b0;
    cnt_load       = 1'b0;
    rd_hs          = 1'b0;
    o_timeout      = 1'b0;
    o_cmd_valid    = 1'b0;
    o_cmd_data     = '0;
    o_wr_valid     = 1'b0;
    o_wr_data      = '0;
    o_req_ready    = '0;
    o_req_rd_valid = '0;
    o_req_rd_data  = '0;
    o_rd_ready     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|i_req_valid) begin
          rr_load   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_cmd_valid        = i_req_valid[g_idx];
        o_wr_valid         = i_req_valid[g_idx];
        o_cmd_data         = i_req_cmd[g_idx];
        o_wr_data          = i_req_wr_data[g_idx];
        o_req_ready[g_idx] = i_cmd_ready;
        // A withdrawn request gives up its turn without moving the pointer.
        if (!i_req_valid[g_idx]) begin
          state_nxt = S_IDLE;
        end else if (i_cmd_ready) begin
          if (i_req_cmd[g_idx].we) begin
            rr_adv    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            cnt_load  = 1'b1;
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        o_req_rd_valid[g_idx] = i_rd_valid;
        o_req_rd_data         = i_rd_data;
        o_rd_ready            = i_req_rd_ready[g_idx];
        rd_hs                 = i_rd_valid && i_req_rd_ready[g_idx];
        if (rd_hs) begin
          if (byte_cnt == I2C_BCNT_W'(1)) begin
            rr_adv    = 1'b1;
            state_nxt = S_IDLE;
          end
`ifdef I2C_CMD_ARB_TIMEOUT_EN
        end else if (wd_cnt == WD_W'(P_TIMEOUT_CYCLES - 1)) begin
          o_timeout = 1'b1;
          rr_adv    = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter (P_NUM_REQ=2, P_TIMEOUT_CYCLES=16): vector table plus read/reset/timeout sequences.
module tb_i2c_cmd_arbiter;
  import package_i2c::*;

  logic                i_clk;
  logic                i_rst_n;
  logic     [1:0]      i_req_valid;
  t_i2c_cmd [1:0]      i_req_cmd;
  logic     [1:0][7:0] i_req_wr_data;
  logic     [1:0]      o_req_ready;
  logic     [1:0]      o_req_rd_valid;
  logic     [7:0]      o_req_rd_data;
  logic     [1:0]      i_req_rd_ready;
  logic     [1:0]      o_grant;
  logic                o_busy;
  logic                o_timeout;
  logic                o_cmd_valid;
  t_i2c_cmd            o_cmd_data;
  logic                o_wr_valid;
  logic     [7:0]      o_wr_data;
  logic                i_cmd_ready;
  logic                i_rd_valid;
  logic     [7:0]      i_rd_data;
  logic                o_rd_ready;

  i2c_cmd_arbiter #(.P_NUM_REQ(2), .P_TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_wr_data(i_req_wr_data),
    .o_req_ready(o_req_ready), .o_req_rd_valid(o_req_rd_valid), .o_req_rd_data(o_req_rd_data),
    .i_req_rd_ready(i_req_rd_ready), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout),
    .o_cmd_valid(o_cmd_valid), .o_cmd_data(o_cmd_data), .o_wr_valid(o_wr_valid), .o_wr_data(o_wr_data),
    .i_cmd_ready(i_cmd_ready), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .o_rd_ready(o_rd_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] req;
    logic       rdy;
    logic [1:0] e_grant;
    logic       e_busy;
    logic       e_cmd_vld;
    logic       e_wr_vld;
    logic [7:0] e_wr_dat;
    logic [1:0] e_req_rdy;
  } vec_t;

  vec_t     vt [15];
  t_i2c_cmd w0, w1, r1;
  logic     pat_v [6];
  logic     pat_r [6];
  logic [7:0] pat_d [6];
  logic [7:0] exp_b [3];
  int       n_pass;
  int       n_total;
  int       nb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_grant"}, 32'(o_grant), 0);
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_timeout"}, 32'(o_timeout), 0);
    chk({nm, "_cmd_vld"}, 32'(o_cmd_valid), 0);
    chk({nm, "_cmd_dat"}, 32'(o_cmd_data), 0);
    chk({nm, "_wr_vld"}, 32'(o_wr_valid), 0);
    chk({nm, "_wr_dat"}, 32'(o_wr_data), 0);
    chk({nm, "_req_rdy"}, 32'(o_req_ready), 0);
    chk({nm, "_req_rd_vld"}, 32'(o_req_rd_valid), 0);
    chk({nm, "_req_rd_dat"}, 32'(o_req_rd_data), 0);
    chk({nm, "_rd_rdy"}, 32'(o_rd_ready), 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    w0 = '{we: 1'b1, sccb_mode: 1'b0, addr_slave: 7'h21, addr_reg: 8'h1E, burst_num: 8'd0};
    w1 = '{we: 1'b1, sccb_mode: 1'b0, addr_slave: 7'h30, addr_reg: 8'h02, burst_num: 8'd0};
    r1 = '{we: 1'b0, sccb_mode: 1'b1, addr_slave: 7'h42, addr_reg: 8'h10, burst_num: 8'd2};

    //          req    rdy   grant  busy  cmdv  wrv   wr_dat rdy_out
    vt[0]  = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[1]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h55, 2'b01};
    vt[2]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[3]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[4]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hAA, 2'b10};
    vt[5]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[6]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h55, 2'b01};
    vt[7]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[8]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hAA, 2'b10};
    vt[9]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[10] = '{2'b11, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 8'h55, 2'b00};
    vt[11] = '{2'b10, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h55, 2'b01};
    vt[12] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vt[13] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h55, 2'b01};
    vt[14] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};

    // Read return pattern: valid gaps and requester-side stalls.
    pat_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pat_r = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pat_d = '{8'hA1, 8'hA2, 8'hA2, 8'h00, 8'hA3, 8'hA3};
    exp_b = '{8'hA1, 8'hA2, 8'hA3};

    // Reset with everything active on the inputs.
    i_rst_n        = 1'b0;
    i_req_valid    = 2'b11;
    i_req_cmd      = {w1, w0};
    i_req_wr_data  = {8'hAA, 8'h55};
    i_req_rd_ready = 2'b11;
    i_cmd_ready    = 1'b1;
    i_rd_valid     = 1'b1;
    i_rd_data      = 8'hEE;
    #2;
    chk_all_zero("reset");
    #6;
    i_req_valid = 2'b00;
    i_rd_valid  = 1'b0;
    i_rd_data   = 8'h00;
    #4 i_rst_n  = 1'b1;

    for (int k = 0; k < 15; k++) begin
      tick();
      i_req_valid = vt[k].req;
      i_cmd_ready = vt[k].rdy;
      #2;
      chk($sformatf("v%0d_grant", k), 32'(o_grant), 32'(vt[k].e_grant));
      chk($sformatf("v%0d_busy", k), 32'(o_busy), 32'(vt[k].e_busy));
      chk($sformatf("v%0d_cmd_vld", k), 32'(o_cmd_valid), 32'(vt[k].e_cmd_vld));
      chk($sformatf("v%0d_wr_vld", k), 32'(o_wr_valid), 32'(vt[k].e_wr_vld));
      chk($sformatf("v%0d_wr_dat", k), 32'(o_wr_data), 32'(vt[k].e_wr_dat));
      chk($sformatf("v%0d_req_rdy", k), 32'(o_req_ready), 32'(vt[k].e_req_rdy));
    end

    // Burst read for req1 (pointer at 1); stray read data in IDLE is dropped.
    tick();
    i_req_cmd      = {r1, w0};
    i_req_valid    = 2'b10;
    i_cmd_ready    = 1'b1;
    i_rd_valid     = 1'b1;
    i_rd_data      = 8'h77;
    i_req_rd_ready = 2'b10;
    #2;
    chk("idle_rd_vld_drop", 32'(o_req_rd_valid), 0);
    chk("idle_rd_rdy", 32'(o_rd_ready), 0);
    tick();
    #2;
    chk("rd_issue_cmd_vld", 32'(o_cmd_valid), 1);
    chk("rd_issue_cmd_dat", 32'(o_cmd_data), 32'(r1));
    chk("rd_issue_grant", 32'(o_grant), 32'(2'b10));
    chk("rd_issue_rd_rdy", 32'(o_rd_ready), 0);
    nb = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      i_req_valid    = 2'b01;
      i_rd_valid     = pat_v[k];
      i_rd_data      = pat_d[k];
      i_req_rd_ready = {pat_r[k], 1'b0};
      #2;
      chk($sformatf("rd%0d_grant", k), 32'(o_grant), 32'(2'b10));
      chk($sformatf("rd%0d_busy", k), 32'(o_busy), 1);
      chk($sformatf("rd%0d_req_rd_vld", k), 32'(o_req_rd_valid), 32'({pat_v[k], 1'b0}));
      chk($sformatf("rd%0d_rd_rdy", k), 32'(o_rd_ready), 32'(pat_r[k]));
      chk($sformatf("rd%0d_cmd_vld", k), 32'(o_cmd_valid), 0);
      chk($sformatf("rd%0d_req_rdy", k), 32'(o_req_ready), 0);
      if (pat_v[k] && pat_r[k] && nb < 3) begin
        chk($sformatf("rd_byte%0d", nb), 32'(o_req_rd_data), 32'(exp_b[nb]));
        nb++;
      end
    end
    tick();
    i_rd_valid = 1'b0;
    #2;
    chk("rd_done_busy", 32'(o_busy), 0);
    tick();
    #2;
    chk("waiter_grant", 32'(o_grant), 32'(2'b01));
    chk("waiter_wr_dat", 32'(o_wr_data), 32'h55);
    tick();
    i_req_valid = 2'b00;

    // Async reset during the second byte of a read.
    tick();
    i_req_valid = 2'b10;
    tick();
    tick();
    i_req_valid    = 2'b00;
    i_rd_valid     = 1'b1;
    i_rd_data      = 8'hA1;
    i_req_rd_ready = 2'b10;
    #2;
    chk("pre_rst_grant", 32'(o_grant), 32'(2'b10));
    tick();
    i_rd_data = 8'hA2;
    #1 i_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    i_rst_n     = 1'b1;
    i_rd_valid  = 1'b0;
    i_req_cmd   = {w1, w0};
    #2;
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_grant", 32'(o_grant), 0);
    tick();
    i_req_valid = 2'b11;
    tick();
    #2;
    chk("post_rst_ptr0", 32'(o_grant), 32'(2'b01));
    tick();
    i_req_valid = 2'b00;

    // Read that never gets data: watchdog at 16 cycles when enabled, otherwise stuck in READ.
    tick();
    i_req_cmd   = {r1, w0};
    i_req_valid = 2'b10;
    tick();
    tick();
    i_req_valid = 2'b00;
    for (int c = 1; c <= 16; c++) begin
`ifdef I2C_CMD_ARB_TIMEOUT_EN
      chk($sformatf("wd_c%0d_timeout", c), 32'(o_timeout), 32'(c == 16));
`else
      chk($sformatf("wd_c%0d_timeout", c), 32'(o_timeout), 0);
`endif
      chk($sformatf("wd_c%0d_busy", c), 32'(o_busy), 1);
      tick();
      #2;
    end
`ifdef I2C_CMD_ARB_TIMEOUT_EN
    chk("wd_after_busy", 32'(o_busy), 0);
    chk("wd_after_rd_rdy", 32'(o_rd_ready), 0);
`else
    chk("wd_after_busy", 32'(o_busy), 1);
    chk("wd_after_rd_rdy", 32'(o_rd_ready), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter P_NUM_REQ, default 2, number of requesters sharing one I2C master (range 2..8).
REQ-002 SHALL have parameter P_TIMEOUT_CYCLES, default 65535, read-stall watchdog limit in i_clk cycles.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: i_clk in 1, i_rst_n in 1.
REQ-004 i_req_valid in P_NUM_REQ: per-requester command valid.
REQ-005 i_req_cmd in P_NUM_REQ x t_i2c_cmd: per-requester command (we, sccb_mode, addr_slave, addr_reg, burst_num).
REQ-006 i_req_wr_data in P_NUM_REQ x 8: per-requester write byte, qualified by i_req_valid.
REQ-007 o_req_ready out P_NUM_REQ: per-requester command accept.
REQ-008 o_req_rd_valid out P_NUM_REQ; o_req_rd_data out 8 (shared); i_req_rd_ready in P_NUM_REQ: read-data return path.
REQ-009 o_grant out P_NUM_REQ one-hot; o_busy out 1; o_timeout out 1 (single-cycle pulse).
REQ-010 Master side: o_cmd_valid out 1, o_cmd_data out t_i2c_cmd, o_wr_valid out 1, o_wr_data out 8, i_cmd_ready in 1, i_rd_valid in 1, i_rd_data in 8, o_rd_ready out 1.

Function
REQ-011 SHALL implement FSM S_IDLE, S_ISSUE, S_READ.
REQ-012 S_IDLE: if any i_req_valid, register grant to the first valid index at or after rr pointer (wrapping); next cycle S_ISSUE; o_grant, o_busy asserted from S_ISSUE.
REQ-013 S_ISSUE: o_cmd_valid = o_wr_valid = i_req_valid[g]; o_cmd_data, o_wr_data from requester g; o_req_ready[g] = i_cmd_ready; all other o_req_ready = 0.
REQ-014 Handshake with we=1: return to S_IDLE; pointer = (g+1) mod P_NUM_REQ.
REQ-015 Handshake with we=0: load byte counter with burst_num+1; go to S_READ.
REQ-016 Counter width SHALL be $bits(burst_num)+1 so burst_num at maximum does not overflow.
REQ-017 S_READ: o_req_rd_valid[g] = i_rd_valid, o_req_rd_data = i_rd_data, o_rd_ready = i_req_rd_ready[g]; counter decrements per handshake; on the last byte go to S_IDLE and advance pointer.
REQ-018 If i_req_valid[g] drops in S_ISSUE before handshake, return to S_IDLE with pointer unchanged.
REQ-019 Grant SHALL NOT change mid-transaction regardless of other requests.
REQ-020 o_rd_ready = 0 outside S_READ; i_rd_valid outside S_READ is dropped.
REQ-021 Decision latency S_IDLE to o_cmd_valid: exactly 1 cycle.

Reset
REQ-022 Asserted i_rst_n: state S_IDLE, pointer 0, counter 0, o_grant 0, o_busy 0, o_timeout 0, all valid/ready outputs 0, data outputs 0.
REQ-023 Reset mid-transaction SHALL abandon it immediately; no pending grant after release.

Configuration
REQ-024 Macro I2C_CMD_ARB_TIMEOUT_EN defined: watchdog counts cycles in S_READ, cleared per read handshake; at P_TIMEOUT_CYCLES go to S_IDLE, pulse o_timeout one cycle, advance pointer.
REQ-025 Macro undefined: no watchdog logic; S_READ waits indefinitely; o_timeout tied 0.

Structure
REQ-026 t_i2c_cmd stays in package_i2c; FSM enum t_i2c_arb_state SHALL be added to package_i2c.
REQ-027 Round-robin selection and pointer SHALL be sub-module i2c_rr_select (inputs requests, advance strobe; outputs one-hot grant, index).

Verification
REQ-028 Req0 write {addr 0x21, reg 0x1E, data 0x55}, i_cmd_ready=1 -> o_cmd_valid one cycle after request, o_wr_data=0x55, o_grant=01, pointer->1.
REQ-029 Req0 and req1 valid continuously, writes -> grants alternate 0,1,0,1; neither starves.
REQ-030 Req1 read burst_num=2, master returns 0xA1,0xA2,0xA3 -> exactly 3 bytes on o_req_rd_data to req1 only, then S_IDLE; req0 request raised mid-read waits.
REQ-031 Read with i_req_rd_ready[g] toggling -> no byte lost or duplicated; o_rd_ready mirrors it.
REQ-032 With I2C_CMD_ARB_TIMEOUT_EN, P_TIMEOUT_CYCLES=16, read with no i_rd_valid -> o_timeout pulses at cycle 16 in S_READ, FSM S_IDLE; without macro, FSM stays in S_READ.
REQ-033 i_rst_n low during S_READ byte 2 -> all outputs 0 same cycle (async), pointer 0 after release.
